// File: rtl/digit_host_spi_master.sv
// SPI mode-0 master driving the recognizer's slave port: streams tx bytes, then rx_len dummy bytes.
// Optional DIGIT_HOST_BYTE_GAP_EN inserts CLK_DIV idle SCK-low cycles between bytes.
module digit_host_spi_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned LEN_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] tx_len,
  input  logic [LEN_W-1:0] rx_len,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             SCK,
  output logic             SS,
  output logic             MOSI,
  input  logic             MISO
);

  localparam int unsigned DivW = $clog2(2 * CLK_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] GapLast = DivW'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StHold,
    StGap,
    StFinish,
    StByteGap
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] tx_left_q, tx_left_d;
  logic [LEN_W-1:0] rx_left_q, rx_left_d;
  logic [7:0]       tx_sr_q, tx_sr_d;
  logic [7:0]       rx_sr_q, rx_sr_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [DivW-1:0]  div_cnt_q, div_cnt_d;
  logic             sck_q, sck_d;
  logic             ss_q, ss_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;

  logic tx_phase;
  logic last_byte;
  logic div_done;

  // The byte in flight is a tx byte while any tx count remains; counters drop at byte end.
  assign tx_phase  = (tx_left_q != '0);
  assign last_byte = tx_phase ? ((tx_left_q == LEN_W'(1)) && (rx_left_q == '0))
                              : (rx_left_q == LEN_W'(1));
  assign div_done  = (div_cnt_q == DivLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tx_left_q  <= '0;
      rx_left_q  <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      sck_q      <= 1'b0;
      ss_q       <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_left_q  <= tx_left_d;
      rx_left_q  <= rx_left_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      sck_q      <= sck_d;
      ss_q       <= ss_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_left_d  = tx_left_q;
    rx_left_d  = rx_left_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    sck_d      = sck_q;
    ss_d       = ss_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_ready   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          tx_left_d = tx_len;
          rx_left_d = rx_len;
          div_cnt_d = '0;
          if ((tx_len == '0) && (rx_len == '0)) begin
            state_d = StFinish;
          end else begin
            state_d = StLoad;
          end
        end
      end

      StLoad: begin
        if (tx_phase) begin
          tx_ready = 1'b1;
          if (tx_valid) begin
            tx_sr_d   = tx_data;
            ss_d      = 1'b0;
            bit_cnt_d = '0;
            div_cnt_d = '0;
            state_d   = StShift;
          end
        end else begin
          tx_sr_d   = '0;
          ss_d      = 1'b0;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = StShift;
        end
      end

      StShift: begin
        if (div_done) begin
          div_cnt_d = '0;
          if (!sck_q) begin
            sck_d   = 1'b1;
            rx_sr_d = {rx_sr_q[6:0], MISO};
          end else begin
            sck_d = 1'b0;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d  = rx_sr_q;
              rx_valid_d = 1'b1;
              // Park MOSI low between bytes and after the frame.
              tx_sr_d    = '0;
              if (tx_phase) begin
                tx_left_d = tx_left_q - LEN_W'(1);
              end else begin
                rx_left_d = rx_left_q - LEN_W'(1);
              end
              if (last_byte) begin
                state_d = StHold;
              end else begin
`ifdef DIGIT_HOST_BYTE_GAP_EN
                state_d = StByteGap;
`else
                state_d = StLoad;
`endif
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              tx_sr_d   = {tx_sr_q[6:0], 1'b0};
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DivW'(1);
        end
      end

      StHold: begin
        if (div_done) begin
          div_cnt_d = '0;
          ss_d      = 1'b1;
          state_d   = StGap;
        end else begin
          div_cnt_d = div_cnt_q + DivW'(1);
        end
      end

      StGap: begin
        if (div_cnt_q == GapLast) begin
          div_cnt_d = '0;
          state_d   = StFinish;
        end else begin
          div_cnt_d = div_cnt_q + DivW'(1);
        end
      end

      StFinish: begin
        state_d = StIdle;
      end

`ifdef DIGIT_HOST_BYTE_GAP_EN
      StByteGap: begin
        if (div_done) begin
          div_cnt_d = '0;
          state_d   = StLoad;
        end else begin
          div_cnt_d = div_cnt_q + DivW'(1);
        end
      end
`endif

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign SCK      = sck_q;
  assign SS       = ss_q;
  assign MOSI     = tx_sr_q[7];
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q != StIdle) && (state_q != StFinish);
  assign done     = (state_q == StFinish);

endmodule
